// File: rtl/mmio_resp_pkg.sv
// rtl/mmio_resp_pkg.sv - MMIO window register select type and address decode helpers
`ifndef MMIO_RESP_DEFS
`define MMIO_RESP_DEFS
`define DATA_W       32
`define ENABLE_N     1'b0
`define DISABLE_N    1'b1
`define MMIO_CONSOLE 16'h1FFC
`define MMIO_STATUS  16'h1FFD
`define MMIO_CYCLES  16'h1FFE
`define MMIO_HALT    16'h1FFF
`define ST_EMPTY     0
`define ST_FULL      1
`define ST_OVF       2
`define ST_COUNT_LSB 8
`endif

package mmio_resp_pkg;

    typedef enum logic [1:0] {
        REG_CONSOLE = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CYCLES  = 2'd2,
        REG_HALT    = 2'd3
    } reg_sel_e;

    localparam logic [15:0] MMIO_BASE = `MMIO_CONSOLE;

    function automatic logic in_window(input logic [15:0] addr);
        return addr[15:2] == MMIO_BASE[15:2];
    endfunction

    // The window is word-aligned on a 4-word boundary, so the low bits select the register.
    function automatic reg_sel_e decode(input logic [15:0] addr);
        return reg_sel_e'(addr[1:0]);
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// rtl/mmio_fifo.sv - console FIFO, power-of-two depth, simultaneous push/pop allowed when full
module mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `ENABLE_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_resp.sv
// rtl/mmio_resp.sv - MMIO responder: console FIFO, status, halt and optional cycle counter (MMIO_CYCLE_CNT_EN)
module mmio_resp
    import mmio_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic [`DATA_W-1:0] wd,
    input  logic               we,
    output logic [`DATA_W-1:0] rd,
    output logic               hit,
    output logic [`DATA_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halt,
    output logic [`DATA_W-1:0] halt_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e           sel;
    logic               wr_console;
    logic               wr_status;
    logic               wr_halt;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               overflow;
    logic [`DATA_W-1:0] status;
    logic [`DATA_W-1:0] cycle_val;

    assign hit        = in_window(a);
    assign sel        = decode(a);
    assign wr_console = we && hit && (sel == REG_CONSOLE);
    assign wr_status  = we && hit && (sel == REG_STATUS);
    assign wr_halt    = we && hit && (sel == REG_HALT);

    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign fifo_push  = wr_console && !halt && (!fifo_full || fifo_pop);

    mmio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (`DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wd),
        .pop       (fifo_pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Stores after halt are ignored outright, so they cannot raise overflow either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `ENABLE_N) begin
            overflow <= 1'b0;
        end else if (wr_status) begin
            overflow <= 1'b0;
        end else if (wr_console && !halt && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `ENABLE_N) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (wr_halt && !halt) begin
            halt      <= 1'b1;
            halt_code <= wd;
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic        wr_cycles;
    logic [31:0] cycles;

    assign wr_cycles = we && hit && (sel == REG_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `ENABLE_N) begin
            cycles <= '0;
        end else if (wr_cycles) begin
            cycles <= '0;
        end else if (!halt) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign cycle_val = `DATA_W'(cycles);
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        status                            = '0;
        status[`ST_COUNT_LSB +: CW]       = fifo_count;
        status[`ST_OVF]                   = overflow;
        status[`ST_FULL]                  = fifo_full;
        status[`ST_EMPTY]                 = fifo_empty;
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (sel)
                REG_CONSOLE: rd = out_data;
                REG_STATUS:  rd = status;
                REG_CYCLES:  rd = cycle_val;
                REG_HALT:    rd[0] = halt;
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_resp.sv
// tb/tb_mmio_resp.sv - directed self-checking bench for mmio_resp
module tb_mmio_resp;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halt;
    logic [31:0] halt_code;

    int n_checks = 0;
    int n_fails  = 0;

    mmio_resp #(.FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .wd        (wd),
        .we        (we),
        .rd        (rd),
        .hit       (hit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halt      (halt),
        .halt_code (halt_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
        end
    endtask

    task automatic mmio_wr(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        check(tag, rd, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = 16'h0000;
        wd        = '0;
        we        = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_halt_code", halt_code, 32'h0);
        rd_chk("rst_status", 16'h1FFD, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the FIFO with 'A'..'H' while the drain side is stalled
        for (int i = 0; i < 8; i++) begin
            mmio_wr(16'h1FFC, 32'h41 + i);
            if (i == 0) begin
                check("first_valid", {31'b0, out_valid}, 32'h1);
                check("first_head", out_data, 32'h41);
            end
        end
        rd_chk("status_full", 16'h1FFD, 32'h0000_0802);
        mmio_wr(16'h1FFC, 32'h49);
        rd_chk("status_ovf", 16'h1FFD, 32'h0000_0806);
        check("head_held", out_data, 32'h41);
        rd_chk("console_rd", 16'h1FFC, 32'h41);
        rd_chk("console_rd_nopop", 16'h1FFD, 32'h0000_0806);

        // Drain 8 while pushing 'I' on the first (full) cycle
        a         = 16'h1FFC;
        wd        = 32'h49;
        we        = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("drain_%0d", k), out_data, 32'h41 + k);
            @(negedge clk);
            we = 1'b0;
        end
        out_ready = 1'b0;
        rd_chk("status_after_drain", 16'h1FFD, 32'h0000_0104);
        check("head_I", out_data, 32'h49);

        mmio_wr(16'h1FFD, 32'hFFFF_FFFF);
        rd_chk("ovf_cleared", 16'h1FFD, 32'h0000_0100);

        mmio_wr(16'h1FFC, 32'h4A);
        mmio_wr(16'h1FFC, 32'h4B);
        mmio_wr(16'h1FFC, 32'h4C);
        rd_chk("status_4", 16'h1FFD, 32'h0000_0400);

        mmio_wr(16'h1FFF, 32'h1);
        check("halt_set", {31'b0, halt}, 32'h1);
        check("halt_code_1", halt_code, 32'h1);
        mmio_wr(16'h1FFF, 32'h2);
        check("halt_code_kept", halt_code, 32'h1);
        rd_chk("halt_rd", 16'h1FFF, 32'h1);
        mmio_wr(16'h1FFC, 32'h5A);
        rd_chk("no_push_after_halt", 16'h1FFD, 32'h0000_0400);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rd_chk("drain_after_halt", 16'h1FFD, 32'h0000_0300);
        check("head_J", out_data, 32'h4A);

        // Asynchronous reset mid-cycle with 3 entries and halt set
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_halt", {31'b0, halt}, 32'h0);
        check("arst_halt_code", halt_code, 32'h0);
        rd_chk("arst_status", 16'h1FFD, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Accesses outside the window
        mmio_wr(16'h0100, 32'hDEAD_BEEF);
        a = 16'h0100;
        #1;
        check("outside_hit", {31'b0, hit}, 32'h0);
        check("outside_rd", rd, 32'h0);
        rd_chk("outside_no_effect", 16'h1FFD, 32'h0000_0001);
        check("outside_valid", {31'b0, out_valid}, 32'h0);
        check("inside_hit", {31'b0, hit}, 32'h1);

`ifdef MMIO_CYCLE_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rd_chk("cycles_100", 16'h1FFE, 32'd100);
        mmio_wr(16'h1FFE, 32'h1234);
        @(negedge clk);
        rd_chk("cycles_cleared", 16'h1FFE, 32'd1);
        mmio_wr(16'h1FFF, 32'h7);
        rd_chk("cycles_at_halt", 16'h1FFE, 32'd3);
        repeat (5) @(negedge clk);
        rd_chk("cycles_frozen", 16'h1FFE, 32'd3);
`else
        rd_chk("cycles_absent", 16'h1FFE, 32'h0);
        mmio_wr(16'h1FFE, 32'h5);
        rd_chk("cycles_absent_wr", 16'h1FFE, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
